// File: rtl/rom_dl_sequencer_if.sv
// Bundle of the ROM download, SDRAM port and PROM signals seen by rom_dl_sequencer.
// Toggle handshake: a port request is outstanding while p*_req != p*_ack; the sequencer flips req to issue and the controller flips ack to complete.
interface rom_dl_sequencer_if;
    logic        ioctl_download;
    logic        ioctl_wr;
    logic [7:0]  ioctl_index;
    logic [24:0] ioctl_addr;
    logic [7:0]  ioctl_dout;
    logic        ioctl_wait;

    logic        p1_req;
    logic        p1_ack;
    logic [22:0] p1_a;
    logic [1:0]  p1_ds;
    logic [15:0] p1_d;

    logic        p2_req;
    logic        p2_ack;
    logic [22:0] p2_a;
    logic [1:0]  p2_ds;
    logic [15:0] p2_d;

    logic        prom_wr;
    logic [9:0]  prom_addr;
    logic [7:0]  prom_data;

    logic        dl_active;
    logic        rom_loaded;
    logic [1:0]  err_flags;
    logic [1:0]  fsm_state;

    modport master (
        input  ioctl_download, ioctl_wr, ioctl_index, ioctl_addr, ioctl_dout, p1_ack, p2_ack,
        output ioctl_wait, p1_req, p1_a, p1_ds, p1_d, p2_req, p2_a, p2_ds, p2_d,
               prom_wr, prom_addr, prom_data, dl_active, rom_loaded, err_flags, fsm_state
    );

    modport slave (
        output ioctl_download, ioctl_wr, ioctl_index, ioctl_addr, ioctl_dout, p1_ack, p2_ack,
        input  ioctl_wait, p1_req, p1_a, p1_ds, p1_d, p2_req, p2_a, p2_ds, p2_d,
               prom_wr, prom_addr, prom_data, dl_active, rom_loaded, err_flags, fsm_state
    );
endinterface

// File: rtl/rom_dl_sequencer.sv
// Routes HPS ROM download bytes to SDRAM port1, SDRAM port2 (sprite swizzle) or the PROM BRAMs,
// and raises rom_loaded once a complete index-0 download has finished.
module rom_dl_sequencer #(
    parameter logic [16:0] SP_BASE   = 17'h10000,
    parameter logic [16:0] PROM_BASE = 17'h1C000,
    parameter logic [16:0] PROM_END  = 17'h1C320,
    parameter logic [7:0]  TIMEOUT   = 8'd255
) (
    input  logic               clk_mem,
    input  logic               reset,
    rom_dl_sequencer_if.master bus
);
    typedef enum logic [1:0] {IDLE = 2'd0, ISSUE = 2'd1, WAIT_ACK = 2'd2} state_t;
    typedef enum logic [1:0] {RG_P1, RG_P2, RG_PROM, RG_NONE} region_t;

    state_t      state;
    region_t     region;
    logic        wr_d;
    logic        dl_d;
    logic        seen;
    logic        dl_ours;
    logic        fall_pend;
    logic [23:0] addr_q;
    logic [7:0]  data_q;
    logic [7:0]  to_cnt;
    logic        byte_ev;
    logic [23:0] sp_off;
    logic [9:0]  prom_off;
    logic        ack_match;

    function automatic region_t decode(input logic [24:0] a);
        if (a < {8'd0, SP_BASE})        return RG_P1;
        else if (a < {8'd0, PROM_BASE}) return RG_P2;
        else if (a < {8'd0, PROM_END})  return RG_PROM;
        else                            return RG_NONE;
    endfunction

    assign byte_ev   = bus.ioctl_wr & ~wr_d & bus.ioctl_download & (bus.ioctl_index == 8'd0);
    assign sp_off    = addr_q - {7'd0, SP_BASE};
    // PROM_BASE is 1 KiB aligned, so the low 10 bits are the BRAM offset
    assign prom_off  = addr_q[9:0] - PROM_BASE[9:0];
    assign ack_match = (region == RG_P2) ? (bus.p2_req == bus.p2_ack) : (bus.p1_req == bus.p1_ack);
    assign bus.fsm_state = state;

    always_ff @(posedge clk_mem or posedge reset) begin
        if (reset) begin
            state          <= IDLE;
            region         <= RG_P1;
            wr_d           <= 1'b0;
            dl_d           <= 1'b0;
            seen           <= 1'b0;
            dl_ours        <= 1'b0;
            fall_pend      <= 1'b0;
            addr_q         <= '0;
            data_q         <= '0;
            to_cnt         <= '0;
            bus.ioctl_wait <= 1'b0;
            bus.p1_req     <= 1'b0;
            bus.p1_a       <= '0;
            bus.p1_ds      <= '0;
            bus.p1_d       <= '0;
            bus.p2_req     <= 1'b0;
            bus.p2_a       <= '0;
            bus.p2_ds      <= '0;
            bus.p2_d       <= '0;
            bus.prom_wr    <= 1'b0;
            bus.prom_addr  <= '0;
            bus.prom_data  <= '0;
            bus.dl_active  <= 1'b0;
            bus.rom_loaded <= 1'b0;
            bus.err_flags  <= '0;
        end else begin
            wr_d          <= bus.ioctl_wr;
            dl_d          <= bus.ioctl_download;
            bus.prom_wr   <= 1'b0;
            bus.dl_active <= bus.ioctl_download | (state != IDLE);

            if (bus.ioctl_download & ~dl_d) begin
                dl_ours <= (bus.ioctl_index == 8'd0);
                if (bus.ioctl_index == 8'd0) begin
                    bus.rom_loaded <= 1'b0;
                    bus.err_flags  <= 2'b00;
                    seen           <= 1'b0;
                    fall_pend      <= 1'b0;
                end
            end
            if (~bus.ioctl_download & dl_d & dl_ours)
                fall_pend <= 1'b1;
            // End of download is only honoured once the last byte has settled
            if (fall_pend && state == IDLE) begin
                fall_pend <= 1'b0;
                if (seen)
                    bus.rom_loaded <= 1'b1;
            end

            case (state)
                IDLE: begin
                    bus.ioctl_wait <= byte_ev;
                    if (byte_ev) begin
                        addr_q <= bus.ioctl_addr[23:0];
                        data_q <= bus.ioctl_dout;
                        region <= decode(bus.ioctl_addr);
                        seen   <= 1'b1;
                        state  <= ISSUE;
                    end
                end
                ISSUE: begin
                    to_cnt <= '0;
                    case (region)
                        RG_P1: begin
                            bus.p1_a   <= addr_q[23:1];
                            bus.p1_ds  <= {addr_q[0], ~addr_q[0]};
                            bus.p1_d   <= {data_q, data_q};
                            bus.p1_req <= ~bus.p1_req;
                            state      <= WAIT_ACK;
                        end
                        RG_P2: begin
                            bus.p2_a   <= {sp_off[23:16], sp_off[13:0], sp_off[15]};
                            bus.p2_ds  <= {sp_off[14], ~sp_off[14]};
                            bus.p2_d   <= {data_q, data_q};
                            bus.p2_req <= ~bus.p2_req;
                            state      <= WAIT_ACK;
                        end
                        RG_PROM: begin
                            bus.prom_wr   <= 1'b1;
                            bus.prom_addr <= prom_off;
                            bus.prom_data <= data_q;
                            state         <= IDLE;
                        end
                        default: begin
                            bus.ioctl_wait <= 1'b0;
                            state          <= IDLE;
                        end
                    endcase
                end
                WAIT_ACK: begin
                    if (ack_match) begin
                        bus.ioctl_wait <= 1'b0;
                        state          <= IDLE;
                    end else if (to_cnt == TIMEOUT) begin
                        // Withdraw the request so the port looks idle to the controller
                        bus.err_flags[0] <= 1'b1;
                        if (region == RG_P2) bus.p2_req <= bus.p2_ack;
                        else                 bus.p1_req <= bus.p1_ack;
                        bus.ioctl_wait <= 1'b0;
                        state          <= IDLE;
                    end else begin
                        to_cnt <= to_cnt + 8'd1;
                    end
                end
                default: state <= IDLE;
            endcase

            if (byte_ev && state != IDLE)
                bus.err_flags[1] <= 1'b1;
        end
    end
endmodule

// File: tb/tb_rom_dl_sequencer.sv
// Randomized scoreboard bench for rom_dl_sequencer: a reference model pushes expected port
// writes into queues and a negedge monitor pops them as the DUT issues requests.
module tb_rom_dl_sequencer;
    logic clk_mem = 1'b0;
    logic reset   = 1'b1;

    rom_dl_sequencer_if bus ();

    rom_dl_sequencer dut (
        .clk_mem (clk_mem),
        .reset   (reset),
        .bus     (bus.master)
    );

    always #5 clk_mem = ~clk_mem;

    int n_checks = 0;
    int n_fail   = 0;
    int exp_p1_cnt = 0, exp_p2_cnt = 0, exp_prom_cnt = 0;
    int got_p1_cnt = 0, got_p2_cnt = 0, got_prom_cnt = 0;
    int p1_force = 0, p2_force = 0;
    bit stuck1 = 0, stuck2 = 0;

    logic [40:0] exp_p1_q[$];
    logic [40:0] exp_p2_q[$];
    logic [17:0] exp_prom_q[$];

    task automatic check(input string name, input logic [127:0] got, input logic [127:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%0h exp=%0h", name, got, exp);
        end
    endtask

    // Reference model: plain arithmetic on the byte address
    task automatic push_expect(input logic [24:0] a, input logic [7:0] d);
        int unsigned ai, s, pa;
        ai = a;
        if (ai < 'h10000) begin
            exp_p1_q.push_back({23'(ai / 2), ((ai % 2) == 1) ? 2'b10 : 2'b01, d, d});
            exp_p1_cnt++;
        end else if (ai < 'h1C000) begin
            s  = ai - 'h10000;
            pa = (s / 65536) * 32768 + (s % 16384) * 2 + (s / 32768) % 2;
            exp_p2_q.push_back({23'(pa), (((s / 16384) % 2) == 1) ? 2'b10 : 2'b01, d, d});
            exp_p2_cnt++;
        end else if (ai < 'h1C320) begin
            exp_prom_q.push_back({10'(ai - 'h1C000), d});
            exp_prom_cnt++;
        end
    endtask

    // SDRAM port responders; ack is cleared by reset like the real controller
    initial begin
        bus.p1_ack = 1'b0;
        forever begin
            @(posedge clk_mem); #1;
            if (reset) bus.p1_ack = 1'b0;
            else if (!stuck1 && bus.p1_req != bus.p1_ack) begin
                repeat ((p1_force > 0) ? p1_force : int'($urandom_range(1, 6))) @(posedge clk_mem);
                #1;
                bus.p1_ack = reset ? 1'b0 : bus.p1_req;
            end
        end
    end

    initial begin
        bus.p2_ack = 1'b0;
        forever begin
            @(posedge clk_mem); #1;
            if (reset) bus.p2_ack = 1'b0;
            else if (!stuck2 && bus.p2_req != bus.p2_ack) begin
                repeat ((p2_force > 0) ? p2_force : int'($urandom_range(1, 6))) @(posedge clk_mem);
                #1;
                bus.p2_ack = reset ? 1'b0 : bus.p2_req;
            end
        end
    end

    // Monitor: a request is issued when req flips away from ack
    initial begin
        logic p1_prev, p2_prev, prom_prev;
        logic [40:0] e;
        logic [17:0] ep;
        p1_prev = 0; p2_prev = 0; prom_prev = 0;
        forever begin
            @(negedge clk_mem);
            if (!reset) begin
                if (bus.p1_req != p1_prev && bus.p1_req != bus.p1_ack) begin
                    got_p1_cnt++;
                    if (exp_p1_q.size() == 0) check("p1_unexpected", 128'(got_p1_cnt), 128'(exp_p1_cnt));
                    else begin
                        e = exp_p1_q.pop_front();
                        check("p1_issue", {bus.p1_a, bus.p1_ds, bus.p1_d}, 128'(e));
                    end
                end
                if (bus.p2_req != p2_prev && bus.p2_req != bus.p2_ack) begin
                    got_p2_cnt++;
                    if (exp_p2_q.size() == 0) check("p2_unexpected", 128'(got_p2_cnt), 128'(exp_p2_cnt));
                    else begin
                        e = exp_p2_q.pop_front();
                        check("p2_issue", {bus.p2_a, bus.p2_ds, bus.p2_d}, 128'(e));
                    end
                end
                if (bus.prom_wr) begin
                    got_prom_cnt++;
                    if (prom_prev) check("prom_wr_width", 128'(2), 128'(1));
                    if (exp_prom_q.size() == 0) check("prom_unexpected", 128'(got_prom_cnt), 128'(exp_prom_cnt));
                    else begin
                        ep = exp_prom_q.pop_front();
                        check("prom_write", {bus.prom_addr, bus.prom_data}, 128'(ep));
                    end
                end
            end
            p1_prev   = bus.p1_req;
            p2_prev   = bus.p2_req;
            prom_prev = bus.prom_wr;
        end
    end

    task automatic pulse_wr(input logic [24:0] a, input logic [7:0] d);
        @(posedge clk_mem); #1;
        bus.ioctl_addr = a;
        bus.ioctl_dout = d;
        bus.ioctl_wr   = 1'b1;
        @(posedge clk_mem); #1;
        bus.ioctl_wr   = 1'b0;
    endtask

    task automatic wait_idle();
        int cnt;
        cnt = 0;
        while (bus.ioctl_wait && cnt < 600) begin
            @(posedge clk_mem); #1;
            cnt++;
        end
        if (cnt >= 600) check("ioctl_wait_timeout", 128'(bus.ioctl_wait), 128'(0));
    endtask

    task automatic send_byte(input logic [24:0] a, input logic [7:0] d, input bit expect_wr);
        pulse_wr(a, d);
        if (expect_wr) push_expect(a, d);
        wait_idle();
    endtask

    task automatic start_dl(input logic [7:0] idx);
        @(posedge clk_mem); #1;
        bus.ioctl_index    = idx;
        bus.ioctl_download = 1'b1;
        repeat (2) @(posedge clk_mem);
        #1;
    endtask

    task automatic end_dl();
        @(posedge clk_mem); #1;
        bus.ioctl_download = 1'b0;
        repeat (4) @(posedge clk_mem);
        #1;
    endtask

    function automatic logic [127:0] all_outputs();
        return 128'({bus.ioctl_wait, bus.p1_req, bus.p1_a, bus.p1_ds, bus.p1_d,
                     bus.p2_req, bus.p2_a, bus.p2_ds, bus.p2_d,
                     bus.prom_wr, bus.prom_addr, bus.prom_data,
                     bus.dl_active, bus.rom_loaded, bus.err_flags, bus.fsm_state});
    endfunction

    initial begin
        #400000;
        n_fail++;
        $display("FAIL watchdog expired at %0t", $time);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        logic [24:0] bnd[$];
        logic [24:0] a;
        bus.ioctl_download = 0;
        bus.ioctl_wr       = 0;
        bus.ioctl_index    = 0;
        bus.ioctl_addr     = 0;
        bus.ioctl_dout     = 0;

        repeat (3) @(posedge clk_mem);
        #1;
        check("reset_outputs", all_outputs(), 128'(0));
        reset = 1'b0;
        repeat (2) @(posedge clk_mem);
        #1;

        // Port1 byte with a 3-cycle ack
        start_dl(8'd0);
        p1_force = 3;
        send_byte(25'h00001, 8'hA5, 1);
        p1_force = 0;
        check("t1_p1_count", 128'(got_p1_cnt), 128'(1));
        check("t1_p2_count", 128'(got_p2_cnt), 128'(0));
        check("t1_dl_active", 128'(bus.dl_active), 128'(1));

        // Sprite swizzle
        send_byte(25'h14001, 8'h3C, 1);
        check("t2_p2_count", 128'(got_p2_cnt), 128'(1));
        check("t2_p1_count", 128'(got_p1_cnt), 128'(1));

        // PROM write and discarded byte
        send_byte(25'h1C205, 8'h7E, 1);
        send_byte(25'h1C400, 8'h99, 0);
        check("t3_prom_count", 128'(got_prom_cnt), 128'(1));
        check("t3_err_clean", 128'(bus.err_flags), 128'(0));
        end_dl();
        check("t3_rom_loaded", 128'(bus.rom_loaded), 128'(1));

        // Stuck port2 ack -> timeout, then normal traffic
        start_dl(8'd0);
        stuck2 = 1;
        send_byte(25'h10020, 8'h12, 1);
        check("t4_err_timeout", 128'(bus.err_flags), 128'(2'b01));
        stuck2 = 0;
        send_byte(25'h10021, 8'h34, 1);
        check("t4_err_sticky", 128'(bus.err_flags), 128'(2'b01));
        check("t4_p2_count", 128'(got_p2_cnt), 128'(exp_p2_cnt));
        end_dl();

        // Overrun: second strobe while waiting for ack is dropped
        start_dl(8'd0);
        check("t5_err_cleared", 128'(bus.err_flags), 128'(0));
        p1_force = 12;
        pulse_wr(25'h00200, 8'h11);
        push_expect(25'h00200, 8'h11);
        repeat (3) @(posedge clk_mem);
        #1;
        pulse_wr(25'h00300, 8'h22);
        wait_idle();
        p1_force = 0;
        repeat (2) @(posedge clk_mem);
        #1;
        check("t5_err_overrun", 128'(bus.err_flags), 128'(2'b10));
        check("t5_p1_count", 128'(got_p1_cnt), 128'(exp_p1_cnt));
        end_dl();

        // Randomized download including region boundaries
        start_dl(8'd0);
        bnd = '{25'h0, 25'h0FFFF, 25'h10000, 25'h17FFF, 25'h18000, 25'h1BFFF,
                25'h1C000, 25'h1C31F, 25'h1C320, 25'h1FFFF, 25'h1FFFFFF};
        foreach (bnd[i]) send_byte(bnd[i], 8'($urandom), 1);
        for (int i = 0; i < 60; i++) begin
            case ($urandom_range(0, 3))
                0:       a = 25'($urandom_range(0, 'hFFFF));
                1:       a = 25'($urandom_range('h10000, 'h1BFFF));
                2:       a = 25'($urandom_range('h1C000, 'h1C31F));
                default: a = 25'($urandom_range('h1C320, 'h1FFFF));
            endcase
            send_byte(a, 8'($urandom), 1);
        end
        end_dl();
        check("t6_rom_loaded", 128'(bus.rom_loaded), 128'(1));
        check("t6_err_clean", 128'(bus.err_flags), 128'(0));
        check("t6_counts", 128'({got_p1_cnt, got_p2_cnt, got_prom_cnt}),
              128'({exp_p1_cnt, exp_p2_cnt, exp_prom_cnt}));

        // Nonzero index: ignored bytes, rom_loaded unchanged
        start_dl(8'd1);
        send_byte(25'h00010, 8'h55, 0);
        send_byte(25'h1C010, 8'h66, 0);
        end_dl();
        check("idx1_rom_loaded", 128'(bus.rom_loaded), 128'(1));

        // Empty index-0 download clears rom_loaded and leaves it clear
        start_dl(8'd0);
        end_dl();
        check("empty_rom_loaded", 128'(bus.rom_loaded), 128'(0));

        // Download ends while a byte is in flight: rom_loaded deferred
        start_dl(8'd0);
        p1_force = 10;
        pulse_wr(25'h00042, 8'h5A);
        push_expect(25'h00042, 8'h5A);
        bus.ioctl_download = 1'b0;
        repeat (2) @(posedge clk_mem);
        #1;
        check("defer_not_yet", 128'(bus.rom_loaded), 128'(0));
        wait_idle();
        repeat (3) @(posedge clk_mem);
        #1;
        check("defer_loaded", 128'(bus.rom_loaded), 128'(1));

        // Reset mid-byte
        start_dl(8'd0);
        pulse_wr(25'h00100, 8'h77);
        push_expect(25'h00100, 8'h77);
        repeat (3) @(posedge clk_mem);
        #1;
        reset = 1'b1;
        #1;
        check("midreset_outputs", all_outputs(), 128'(0));
        bus.ioctl_download = 1'b0;
        repeat (15) @(posedge clk_mem);
        #1;
        reset = 1'b0;
        p1_force = 0;
        repeat (3) @(posedge clk_mem);
        #1;
        check("postreset_rom_loaded", 128'(bus.rom_loaded), 128'(0));

        check("final_p1_q_empty", 128'(exp_p1_q.size()), 128'(0));
        check("final_p2_q_empty", 128'(exp_p2_q.size()), 128'(0));
        check("final_prom_q_empty", 128'(exp_prom_q.size()), 128'(0));
        check("final_counts", 128'({got_p1_cnt, got_p2_cnt, got_prom_cnt}),
              128'({exp_p1_cnt, exp_p2_cnt, exp_prom_cnt}));

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
